fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Ports:
//   clk, rst          write-domain clock, asynchronous active-high reset
//   req_valid/data    per-requester valid and packed data (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready         per-requester accept, one-hot or zero
//   fifo_full/almost  FIFO back-pressure flags (almost-full only gates new grants)
//   fifo_wen/wdata    FIFO write port
//   grant_id          current or most recent grantee
//   busy              high while a burst is in progress
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int IW = $clog2(NUM_REQ),
    localparam int BW = $clog2(MAX_BURST) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_wen,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [IW-1:0] pick, idx;
    logic          found;
    logic          sel_valid;
    logic [IW-1:0] gid_next;

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        pick  = rr_q;
        idx   = rr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(rr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Outputs depend only on the registered grantee, so a non-granted
    // requester's valid never reaches an output combinationally.
    assign sel_valid  = req_valid[gid_q];
    assign busy       = state_q == BURST;
    assign fifo_wen   = busy && sel_valid && !fifo_full;
    assign fifo_wdata = req_data[gid_q*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id   = gid_q;
    assign gid_next   = gid_q == IW'(NUM_REQ - 1) ? '0 : gid_q + IW'(1);

    always_comb begin
        req_ready        = '0;
        req_ready[gid_q] = busy && !fifo_full;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        beat_d  = beat_q;
        if (state_q == IDLE) begin
            if (found && !fifo_almost_full) begin
                gid_d   = pick;
                beat_d  = '0;
                state_d = BURST;
            end
        end else if (!sel_valid) begin
            state_d = IDLE;
            rr_d    = gid_next;
        end else if (fifo_wen) begin
            if (beat_q == BW'(MAX_BURST - 1)) begin
                state_d = IDLE;
                rr_d    = gid_next;
            end else begin
                beat_d  = beat_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gid_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            beat_q  <= beat_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;
    logic        clk, rst;
    logic [3:0]  req_valid, req_ready;
    logic [7:0]  dd [4];
    logic [31:0] req_data;
    logic        fifo_full, fifo_almost_full, fifo_wen, busy;
    logic [7:0]  fifo_wdata;
    logic [1:0]  grant_id;
    int          vecs = 0;
    int          errs = 0;

    assign req_data = {dd[3], dd[2], dd[1], dd[0]};

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Settle 1 time unit, then compare {busy, wen, ready, grant_id, wdata};
    // wdata is only meaningful when a write is expected.
    task automatic look(input string tag, input logic b, input logic w,
                        input logic [3:0] r, input logic [1:0] g, input logic [7:0] wd);
        logic [15:0] obs, exp;
        #1;
        obs = {busy, fifo_wen, req_ready, grant_id, w ? fifo_wdata : 8'h00};
        exp = {b, w, r, g, w ? wd : 8'h00};
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got busy/wen/rdy/gid/wdata=%h required %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        for (int i = 0; i < 4; i++) dd[i] = '0;
        look("reset", 0, 0, 4'b0000, 0, 0);
        step();
        rst = 1'b0;

        // Single requester 2, six words: 4-beat burst, 1 idle cycle, 2-beat burst.
        step();
        req_valid = 4'b0100;
        dd[2] = 8'h10;
        look("t1 idle", 0, 0, 4'b0000, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            dd[2] = 8'h10 + 8'(k);
            look("t1 burst a", 1, 1, 4'b0100, 2, 8'h10 + 8'(k));
        end
        step();
        dd[2] = 8'h14;
        look("t1 gap", 0, 0, 4'b0000, 2, 0);
        for (int k = 4; k < 6; k++) begin
            step();
            dd[2] = 8'h10 + 8'(k);
            look("t1 burst b", 1, 1, 4'b0100, 2, 8'h10 + 8'(k));
        end
        step();
        req_valid = 4'b0000;
        look("t1 drop", 1, 0, 4'b0100, 2, 0);
        step();
        look("t1 end", 0, 0, 4'b0000, 2, 0);

        // Round robin with all requesters valid: 0,1,2,3,0, 5 cycles per grant.
        do_reset();
        step();
        for (int i = 0; i < 4; i++) dd[i] = 8'hA0 + 8'(i);
        req_valid = 4'b1111;
        look("t2 idle", 0, 0, 4'b0000, 0, 0);
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++) begin
                step();
                look("t2 beat", 1, 1, 4'(1 << g), 2'(g), 8'hA0 + 8'(g));
            end
            step();
            look("t2 gap", 0, 0, 4'b0000, 2'(g), 0);
        end
        step();
        look("t2 wrap", 1, 1, 4'b0001, 0, 8'hA0);

        // Full stall on beat 2 of a grant to requester 1.
        do_reset();
        step();
        req_valid = 4'b0010;
        dd[1] = 8'h30;
        look("t3 idle", 0, 0, 4'b0000, 0, 0);
        step();
        look("t3 beat0", 1, 1, 4'b0010, 1, 8'h30);
        step();
        dd[1] = 8'h31;
        look("t3 beat1", 1, 1, 4'b0010, 1, 8'h31);
        step();
        dd[1] = 8'h32;
        fifo_full = 1'b1;
        look("t3 stall", 1, 0, 4'b0000, 1, 0);
        step();
        look("t3 stall", 1, 0, 4'b0000, 1, 0);
        step();
        look("t3 stall", 1, 0, 4'b0000, 1, 0);
        step();
        fifo_full = 1'b0;
        look("t3 beat2", 1, 1, 4'b0010, 1, 8'h32);
        step();
        dd[1] = 8'h33;
        look("t3 beat3", 1, 1, 4'b0010, 1, 8'h33);
        step();
        dd[1] = 8'h34;
        look("t3 end", 0, 0, 4'b0000, 1, 0);

        // Almost-full gates new grants only, not a burst in progress.
        do_reset();
        step();
        dd[0] = 8'h40;
        dd[3] = 8'h43;
        req_valid = 4'b1001;
        fifo_almost_full = 1'b1;
        look("t4 gated", 0, 0, 4'b0000, 0, 0);
        step();
        look("t4 gated", 0, 0, 4'b0000, 0, 0);
        step();
        fifo_almost_full = 1'b0;
        look("t4 release", 0, 0, 4'b0000, 0, 0);
        step();
        look("t4 beat0", 1, 1, 4'b0001, 0, 8'h40);
        step();
        fifo_almost_full = 1'b1;
        look("t4 beat1 af", 1, 1, 4'b0001, 0, 8'h40);
        step();
        look("t4 beat2 af", 1, 1, 4'b0001, 0, 8'h40);
        step();
        look("t4 beat3 af", 1, 1, 4'b0001, 0, 8'h40);
        step();
        look("t4 idle", 0, 0, 4'b0000, 0, 0);
        step();
        look("t4 held", 0, 0, 4'b0000, 0, 0);

        // Early end: requester 0 drops after 2 beats; next grant goes to 1.
        do_reset();
        step();
        dd[0] = 8'h50;
        dd[1] = 8'h51;
        req_valid = 4'b0011;
        look("t5 idle", 0, 0, 4'b0000, 0, 0);
        step();
        look("t5 beat0", 1, 1, 4'b0001, 0, 8'h50);
        step();
        look("t5 beat1", 1, 1, 4'b0001, 0, 8'h50);
        step();
        req_valid = 4'b0010;
        look("t5 drop", 1, 0, 4'b0001, 0, 0);
        step();
        look("t5 idle2", 0, 0, 4'b0000, 0, 0);
        step();
        look("t5 next", 1, 1, 4'b0010, 1, 8'h51);

        // Async reset between edges mid-burst.
        #1;
        rst = 1'b1;
        look("t6 async", 0, 0, 4'b0000, 0, 0);
        step();
        rst = 1'b0;
        req_valid = 4'b0011;
        look("t6 idle", 0, 0, 4'b0000, 0, 0);
        step();
        look("t6 grant", 1, 1, 4'b0001, 0, 8'h50);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
